// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters (CPU, loader), the arbiter and the memory macro.
interface mem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_done;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/memory environment view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port memory: CPU priority with a
// bounded-wait guarantee for the loader, each access run as issue/wait/done.
module mem_arbiter #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned LAT    = 1,
    parameter int unsigned STARVE = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned SW = 4;
    localparam int unsigned WW = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic          r_owner,     w_owner_nxt;   // 1 = loader owns the access
    logic [SW-1:0] r_starve,    w_starve_nxt;
    logic [WW-1:0] r_wait,      w_wait_nxt;
    logic          r_mem_en,    w_mem_en_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DW-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DW-1:0] r_ldr_rdata, w_ldr_rdata_nxt;
    logic          r_cpu_done,  w_cpu_done_nxt;
    logic          r_ldr_done,  w_ldr_done_nxt;
    logic          w_grant_ldr;

    // The mem_* registers double as the latched request fields, so they hold outside ISSUE.
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_starve_nxt    = r_starve;
        w_wait_nxt      = r_wait;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_ldr_rdata_nxt = r_ldr_rdata;
        w_cpu_done_nxt  = 1'b0;
        w_ldr_done_nxt  = 1'b0;
        w_grant_ldr     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req || bus.ldr_req) begin
                    w_grant_ldr     = bus.ldr_req && (!bus.cpu_req || (r_starve == SW'(STARVE)));
                    w_owner_nxt     = w_grant_ldr;
                    w_mem_we_nxt    = w_grant_ldr ? bus.ldr_we    : bus.cpu_we;
                    w_mem_addr_nxt  = w_grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
                    w_mem_wdata_nxt = w_grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                    w_mem_en_nxt    = 1'b1;
                    w_state_nxt     = S_ISSUE;
                    if (w_grant_ldr) begin
                        w_starve_nxt = '0;
                    end else if (bus.ldr_req && (r_starve != SW'(STARVE))) begin
                        w_starve_nxt = r_starve + SW'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (r_mem_we) begin
                    w_state_nxt    = S_DONE;
                    w_cpu_done_nxt = !r_owner;
                    w_ldr_done_nxt = r_owner;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = '0;
                end
            end
            S_WAIT: begin
                if (r_wait == WW'(LAT - 1)) begin
                    if (r_owner) w_ldr_rdata_nxt = bus.mem_rdata;
                    else         w_cpu_rdata_nxt = bus.mem_rdata;
                    w_wait_nxt     = '0;
                    w_state_nxt    = S_DONE;
                    w_cpu_done_nxt = !r_owner;
                    w_ldr_done_nxt = r_owner;
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_starve    <= '0;
            r_wait      <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_cpu_done  <= 1'b0;
            r_ldr_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_starve    <= w_starve_nxt;
            r_wait      <= w_wait_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_ldr_rdata <= w_ldr_rdata_nxt;
            r_cpu_done  <= w_cpu_done_nxt;
            r_ldr_done  <= w_ldr_done_nxt;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ldr_rdata = r_ldr_rdata;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.ldr_done  = r_ldr_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single accesses, contention/starvation,
// reset during a read and a request arriving mid-access.
module tb_mem_arbiter;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned LAT    = 3;
    localparam int unsigned STARVE = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] exp_cpu_rd;
    logic [7:0] exp_ldr_rd;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE(STARVE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Memory model: preset contents (addr ^ 0xE3) on reset, reads appear LAT cycles after mem_en
    logic [7:0] mem  [256];
    logic [7:0] pipe [LAT];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hE3;
            for (int i = 0; i < int'(LAT); i++) pipe[i] <= 8'h00;
        end else begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 8'h00;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.mem_rdata = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.cpu_req = 1'b0;
        bus.ldr_req = 1'b0;
    endtask

    // One uncontended access, request raised in the current (IDLE) cycle
    task automatic access(input bit ldr, input bit we, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        int cyc = 0;
        int en_cyc = -1;
        int n_en = 0;
        bit other = 1'b0;
        bit got = 1'b0;
        if (ldr) begin
            bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wd;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        end
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (bus.mem_en) begin
                n_en++;
                if (en_cyc < 0) en_cyc = cyc;
                check("mem_addr", 32'(bus.mem_addr), 32'(addr));
                check("mem_we", 32'(bus.mem_we), 32'(we));
                if (we) check("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
            end
            if (ldr ? bus.cpu_done : bus.ldr_done) other = 1'b1;
            got = ldr ? bus.ldr_done : bus.cpu_done;
        end
        check("en_cycle", 32'(en_cyc), 32'd1);
        check("en_count", 32'(n_en), 32'd1);
        check("done_latency", 32'(cyc), we ? 32'd2 : 32'(2 + LAT));
        check("other_done", 32'(other), 32'd0);
        if (!we) begin
            if (ldr) exp_ldr_rd = exp_rd;
            else     exp_cpu_rd = exp_rd;
        end
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rd));
        check("ldr_rdata", 32'(bus.ldr_rdata), 32'(exp_ldr_rd));
        drop_reqs();
        tick();
        check("done_pulse", 32'({bus.cpu_done, bus.ldr_done}), 32'd0);
        check("rdata_hold", 32'({bus.cpu_rdata, bus.ldr_rdata}), 32'({exp_cpu_rd, exp_ldr_rd}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_done;
        int cyc;
        int last_cyc;
        bit both;
        int c_en;
        int c_ldone;
        int c_cdone;

        exp_cpu_rd = 8'h00;
        exp_ldr_rd = 8'h00;
        reset_n = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h01; bus.cpu_wdata = 8'hFF;
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 8'h02; bus.ldr_wdata = 8'hEE;

        // Reset held with both requests high: everything stays quiet
        repeat (3) tick();
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_strobes", 32'({bus.mem_we, bus.cpu_done, bus.ldr_done}), 32'd0);
        check("rst_mem_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
        check("rst_rdata", 32'({bus.cpu_rdata, bus.ldr_rdata}), 32'd0);
        drop_reqs();
        tick();
        reset_n = 1'b1;
        tick();

        // CPU write then read back; loader read data untouched
        access(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00);
        access(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
        // Loader alone reads a preset location
        access(1'b1, 1'b0, 8'h20, 8'h00, 8'hC3);
        // Loader write leaves both rdata registers alone; CPU sees the new data
        access(1'b1, 1'b1, 8'h30, 8'h77, 8'h00);
        access(1'b0, 1'b0, 8'h30, 8'h00, 8'h77);

        // Contention: both hold write requests; expect C,C,C,C,L repeating every 3 cycles
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h50; bus.cpu_wdata = 8'hA1;
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 8'h60; bus.ldr_wdata = 8'hB2;
        n_done = 0; cyc = 0; last_cyc = 0; both = 1'b0;
        while (n_done < 10 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.cpu_done && bus.ldr_done) both = 1'b1;
            if (bus.cpu_done || bus.ldr_done) begin
                check($sformatf("grant%0d_ldr", n_done), 32'(bus.ldr_done), 32'((n_done % 5) == 4));
                check($sformatf("grant%0d_gap", n_done), 32'(cyc - last_cyc), n_done == 0 ? 32'd2 : 32'd3);
                last_cyc = cyc;
                n_done++;
                if (n_done == 10) drop_reqs();
            end
        end
        check("contention_count", 32'(n_done), 32'd10);
        check("dual_done", 32'(both), 32'd0);
        tick();

        // Reset during a loader read: no done, rdata cleared, re-issue completes
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 8'h20;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_en", 32'({bus.mem_en, bus.ldr_done, bus.cpu_done}), 32'd0);
        both = 1'b0;
        repeat (4) begin
            tick();
            if (bus.ldr_done || bus.cpu_done || bus.mem_en) both = 1'b1;
        end
        check("midrst_quiet", 32'(both), 32'd0);
        check("midrst_rdata", 32'({bus.cpu_rdata, bus.ldr_rdata}), 32'd0);
        exp_cpu_rd = 8'h00;
        exp_ldr_rd = 8'h00;
        drop_reqs();
        reset_n = 1'b1;
        tick();
        access(1'b1, 1'b0, 8'h20, 8'h00, 8'hC3);

        // CPU request arriving while the loader read is in WAIT waits for the next IDLE
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 8'h20;
        c_en = -1; c_ldone = -1; c_cdone = -1; cyc = 0;
        while (c_cdone < 0 && cyc < 30) begin
            tick();
            cyc++;
            if (cyc == 2) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h40; bus.cpu_wdata = 8'h11;
            end
            if (cyc >= 2 && bus.mem_en && c_en < 0) begin
                c_en = cyc;
                check("late_addr", 32'(bus.mem_addr), 32'h40);
            end
            if (bus.ldr_done) begin
                c_ldone = cyc;
                check("late_ldr_rdata", 32'(bus.ldr_rdata), 32'hC3);
                bus.ldr_req = 1'b0;
            end
            if (bus.cpu_done) begin
                c_cdone = cyc;
                bus.cpu_req = 1'b0;
            end
        end
        check("late_ldr_done", 32'(c_ldone), 32'(2 + LAT));
        check("late_cpu_en", 32'(c_en), 32'(4 + LAT));
        check("late_cpu_done", 32'(c_cdone), 32'(5 + LAT));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
